instr_fetch: RTL and testbench

Instruction-fetch sequencer for the multicycle processor. It reads the program counter value, presents it to instruction memory, and waits a fixed memory latency. It then captures the instruction into IR and hands it to the execute control through a valid/ready handshake. It drives the program counter's increment and load controls, so it sits directly upstream of the PC counter and consumes the counter's output.

---
 rtl/instr_fetch_if.sv | 29 ++
 rtl/instr_fetch.sv | 126 ++++++++++++
 tb/tb_instr_fetch.sv | 363 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_if.sv
// Fetch-side bus bundle: PC counter controls, instruction memory port and the
// IR valid/ready handshake towards execute control.
interface instr_fetch_if #(
  parameter int W = 16
);
  logic         Run;
  logic [W-1:0] PC;
  logic [W-1:0] MemData;
  logic [W-1:0] MemAddr;
  logic         PCIncr;
  logic         PCLoad;
  logic [W-1:0] PCTarget;
  logic [W-1:0] IR;
  logic         IRValid;
  logic         IRReady;
  logic         BranchReq;
  logic [W-1:0] BranchAddr;
  logic         Busy;

  modport master (
    input  Run, PC, MemData, IRReady, BranchReq, BranchAddr,
    output MemAddr, PCIncr, PCLoad, PCTarget, IR, IRValid, Busy
  );

  modport slave (
    output Run, PC, MemData, IRReady, BranchReq, BranchAddr,
    input  MemAddr, PCIncr, PCLoad, PCTarget, IR, IRValid, Busy
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction-fetch sequencer: issues PC to memory, waits MEM_LATENCY edges,
// captures IR and hands it to execute over valid/ready; handles redirects.
module instr_fetch #(
  parameter int MEM_LATENCY = 2,
  parameter int W           = 16
) (
  input  logic           Clock,
  input  logic           Resetn,
  instr_fetch_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_HOLD,
    S_REDIR
  } state_e;

  state_e       state_q, state_d;
  logic [2:0]   cnt_q, cnt_d;
  logic [W-1:0] mem_addr_q, mem_addr_d;
  logic [W-1:0] ir_q, ir_d;
  logic [W-1:0] pc_target_q, pc_target_d;
  logic         ir_valid_q, ir_valid_d;
  logic         pc_incr_q, pc_incr_d;
  logic         pc_load_q, pc_load_d;
  logic         busy_q, busy_d;

  logic handshake;
  logic branch;

  assign handshake = ir_valid_q && bus.IRReady;
  assign branch    = bus.BranchReq &&
                     (state_q == S_ISSUE || state_q == S_WAIT || state_q == S_HOLD);

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_addr_d  = mem_addr_q;
    ir_d        = ir_q;
    pc_target_d = pc_target_q;
    ir_valid_d  = ir_valid_q;
    pc_incr_d   = 1'b0;
    pc_load_d   = 1'b0;

    if (branch) begin
      // Redirect abandons whatever is in flight; a same-edge handshake still
      // consumes IR since IRValid drops here either way.
      state_d     = S_REDIR;
      pc_target_d = bus.BranchAddr;
      ir_valid_d  = 1'b0;
      pc_load_d   = 1'b1;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.Run) state_d = S_ISSUE;
        end
        S_ISSUE: begin
          mem_addr_d = bus.PC;
          cnt_d      = 3'(MEM_LATENCY);
          state_d    = S_WAIT;
        end
        S_WAIT: begin
          cnt_d = cnt_q - 3'd1;
          if (cnt_q == 3'd1) begin
            ir_d       = bus.MemData;
            ir_valid_d = 1'b1;
            pc_incr_d  = 1'b1;
            state_d    = S_HOLD;
          end
        end
        S_HOLD: begin
          if (handshake) begin
            ir_valid_d = 1'b0;
            state_d    = bus.Run ? S_ISSUE : S_IDLE;
          end
        end
        S_REDIR: begin
          state_d = S_ISSUE;
        end
        default: state_d = S_IDLE;
      endcase
    end

    busy_d = (state_d != S_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      mem_addr_q  <= '0;
      ir_q        <= '0;
      pc_target_q <= '0;
      ir_valid_q  <= 1'b0;
      pc_incr_q   <= 1'b0;
      pc_load_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_addr_q  <= mem_addr_d;
      ir_q        <= ir_d;
      pc_target_q <= pc_target_d;
      ir_valid_q  <= ir_valid_d;
      pc_incr_q   <= pc_incr_d;
      pc_load_q   <= pc_load_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.MemAddr  = mem_addr_q;
  assign bus.IR       = ir_q;
  assign bus.PCTarget = pc_target_q;
  assign bus.IRValid  = ir_valid_q;
  assign bus.PCIncr   = pc_incr_q;
  assign bus.PCLoad   = pc_load_q;
  assign bus.Busy     = busy_q;

  cfg_latency_legal: assert property (@(posedge Clock) (MEM_LATENCY >= 1 && MEM_LATENCY <= 7))
    else $error("instr_fetch: MEM_LATENCY %0d outside 1..7", MEM_LATENCY);

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: PC counter and async-read memory live
// here; expected fetches come from a program-order model over a random memory.
module tb_instr_fetch;
  localparam int LAT    = 2;
  localparam int W      = 16;
  localparam int BUDGET = 20;

  logic Clock;
  logic Resetn;
  int   tests_run;
  int   tests_failed;

  logic [W-1:0] mem [256];
  logic [W-1:0] pc_cnt;
  int           incr_cnt;
  int           load_cnt;
  int           overlap_cnt;

  instr_fetch_if #(.W(W)) bus ();

  instr_fetch #(.MEM_LATENCY(LAT), .W(W)) dut (
    .Clock  (Clock),
    .Resetn (Resetn),
    .bus    (bus)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  assign bus.PC      = pc_cnt;
  assign bus.MemData = mem[bus.MemAddr[7:0]];

  // Environment PC counter: updates mid-cycle so ISSUE sees the new value.
  always @(negedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      pc_cnt <= '0;
    end else begin
      if (bus.PCLoad)      pc_cnt <= bus.PCTarget;
      else if (bus.PCIncr) pc_cnt <= pc_cnt + 16'd1;
      if (bus.PCIncr) incr_cnt <= incr_cnt + 1;
      if (bus.PCLoad) load_cnt <= load_cnt + 1;
      if (bus.PCIncr && bus.PCLoad) overlap_cnt <= overlap_cnt + 1;
    end
  end

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!bus.IRValid && n < BUDGET);
    if (!bus.IRValid) begin
      tests_run++;
      tests_failed++;
      $display("FAIL wait_valid: IRValid still 0 after %0d cycles", n);
    end
  endtask

  task automatic do_reset();
    Resetn = 1'b0; Run_set(1'b1);
    bus.IRReady = 1'b0; bus.BranchReq = 1'b0; bus.BranchAddr = '0;
    repeat (2) step();
    Resetn = 1'b1;
  endtask

  task automatic Run_set(input logic v);
    bus.Run = v;
  endtask

  task automatic test_reset();
    int n;
    Resetn = 1'b0; bus.Run = 1'b1; bus.IRReady = 1'b0; bus.BranchReq = 1'b0; bus.BranchAddr = '0;
    repeat (3) step();
    tests_run++;
    if ({bus.MemAddr, bus.IR, bus.PCTarget, bus.IRValid, bus.PCIncr, bus.PCLoad, bus.Busy} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %h required 0",
               {bus.MemAddr, bus.IR, bus.PCTarget, bus.IRValid, bus.PCIncr, bus.PCLoad, bus.Busy});
    end
    Resetn = 1'b1;
    step();
    tests_run++;
    if (bus.Busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL start_busy: got %b required 1", bus.Busy);
    end
    step();
    tests_run++;
    if (bus.MemAddr !== 16'h0000 || bus.IRValid !== 1'b0) begin
      tests_failed++;
      $display("FAIL start_addr: MemAddr %h IRValid %b required 0000/0", bus.MemAddr, bus.IRValid);
    end
    wait_valid(n);
    tests_run++;
    if (2 + n != LAT + 2 || bus.IR !== 16'h1234 || bus.PCIncr !== 1'b1) begin
      tests_failed++;
      $display("FAIL start_capture: edge %0d IR %h PCIncr %b required edge %0d IR 1234 PCIncr 1",
               2 + n, bus.IR, bus.PCIncr, LAT + 2);
    end
  endtask

  // Continues from test_reset: first instruction is pending in HOLD.
  task automatic test_backpressure();
    int inc0;
    inc0 = incr_cnt;
    for (int i = 0; i < 5; i++) begin
      step();
      tests_run++;
      if (bus.IR !== 16'h1234 || bus.IRValid !== 1'b1 || bus.PCIncr !== 1'b0) begin
        tests_failed++;
        $display("FAIL stall_%0d: IR %h IRValid %b PCIncr %b required 1234/1/0",
                 i, bus.IR, bus.IRValid, bus.PCIncr);
      end
    end
    tests_run++;
    if (incr_cnt != inc0 + 1) begin
      tests_failed++;
      $display("FAIL stall_incr_count: got %0d required %0d", incr_cnt - inc0, 1);
    end
    bus.IRReady = 1'b1;
    step();
    bus.IRReady = 1'b0;
    tests_run++;
    if (bus.IRValid !== 1'b0) begin
      tests_failed++;
      $display("FAIL release_valid: got %b required 0", bus.IRValid);
    end
    step();
    tests_run++;
    if (bus.MemAddr !== 16'h0001) begin
      tests_failed++;
      $display("FAIL next_addr: got %h required 0001", bus.MemAddr);
    end
  endtask

  task automatic test_stream();
    int n;
    int inc0;
    do_reset();
    inc0 = incr_cnt;
    bus.IRReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_valid(n);
      if (i == 3) bus.IRReady = 1'b0;
      tests_run++;
      if (n != LAT + 2 || bus.MemAddr !== 16'(i) || bus.IR !== mem[i]) begin
        tests_failed++;
        $display("FAIL stream_%0d: gap %0d addr %h IR %h required gap %0d addr %h IR %h",
                 i, n, bus.MemAddr, bus.IR, LAT + 2, 16'(i), mem[i]);
      end
    end
    step();
    tests_run++;
    if (incr_cnt - inc0 != 4) begin
      tests_failed++;
      $display("FAIL stream_incr_count: got %0d required 4", incr_cnt - inc0);
    end
  endtask

  // Random stall lengths; model: accepted IR k equals mem[k] in program order.
  task automatic test_random_stream();
    int n;
    int stall;
    int inc0;
    logic [W-1:0] exp_pc;
    do_reset();
    inc0   = incr_cnt;
    exp_pc = '0;
    for (int i = 0; i < 16; i++) begin
      wait_valid(n);
      tests_run++;
      if (n != ((i == 0) ? LAT + 2 : LAT + 1) || bus.MemAddr !== exp_pc ||
          bus.IR !== mem[exp_pc[7:0]] || bus.PCIncr !== 1'b1) begin
        tests_failed++;
        $display("FAIL rand_fetch_%0d: gap %0d addr %h IR %h PCIncr %b required addr %h IR %h",
                 i, n, bus.MemAddr, bus.IR, bus.PCIncr, exp_pc, mem[exp_pc[7:0]]);
      end
      stall = $urandom_range(0, 3);
      repeat (stall) begin
        step();
        tests_run++;
        if (bus.IRValid !== 1'b1 || bus.IR !== mem[exp_pc[7:0]]) begin
          tests_failed++;
          $display("FAIL rand_hold_%0d: IRValid %b IR %h required 1/%h",
                   i, bus.IRValid, bus.IR, mem[exp_pc[7:0]]);
        end
      end
      bus.IRReady = 1'b1;
      step();
      bus.IRReady = 1'b0;
      exp_pc = exp_pc + 16'd1;
    end
    tests_run++;
    if (incr_cnt - inc0 != 16) begin
      tests_failed++;
      $display("FAIL rand_incr_count: got %0d required 16", incr_cnt - inc0);
    end
  endtask

  task automatic test_branch_wait();
    int n;
    int inc0;
    int ld0;
    logic [W-1:0] ir_before;
    do_reset();
    wait_valid(n);
    ir_before = bus.IR;
    bus.IRReady = 1'b1;
    step();
    bus.IRReady = 1'b0;
    step();
    inc0 = incr_cnt;
    ld0  = load_cnt;
    bus.BranchReq = 1'b1; bus.BranchAddr = 16'h0040;
    step();
    bus.BranchReq = 1'b0;
    tests_run++;
    if (bus.PCLoad !== 1'b1 || bus.PCTarget !== 16'h0040 || bus.IRValid !== 1'b0 || bus.PCIncr !== 1'b0) begin
      tests_failed++;
      $display("FAIL bw_redir: PCLoad %b PCTarget %h IRValid %b PCIncr %b required 1/0040/0/0",
               bus.PCLoad, bus.PCTarget, bus.IRValid, bus.PCIncr);
    end
    step();
    tests_run++;
    if (bus.PCLoad !== 1'b0) begin
      tests_failed++;
      $display("FAIL bw_load_width: PCLoad %b required 0", bus.PCLoad);
    end
    step();
    tests_run++;
    if (bus.MemAddr !== 16'h0040 || bus.IR !== ir_before || incr_cnt != inc0 || load_cnt != ld0 + 1) begin
      tests_failed++;
      $display("FAIL bw_target: addr %h IR %h incr %0d load %0d required 0040/%h/0/1",
               bus.MemAddr, bus.IR, incr_cnt - inc0, load_cnt - ld0, ir_before);
    end
    wait_valid(n);
    tests_run++;
    if (n != LAT || bus.IR !== mem[8'h40]) begin
      tests_failed++;
      $display("FAIL bw_fetch: gap %0d IR %h required %0d/%h", n, bus.IR, LAT, mem[8'h40]);
    end
  endtask

  task automatic test_branch_handshake();
    int n;
    int ld0;
    logic [W-1:0] tgt;
    do_reset();
    wait_valid(n);
    ld0 = load_cnt;
    tgt = 16'($urandom_range(16, 255));
    bus.IRReady = 1'b1; bus.BranchReq = 1'b1; bus.BranchAddr = tgt;
    step();
    bus.IRReady = 1'b0; bus.BranchReq = 1'b0;
    tests_run++;
    if (bus.IRValid !== 1'b0 || bus.PCLoad !== 1'b1 || bus.PCTarget !== tgt || bus.Busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL bh_edge: IRValid %b PCLoad %b PCTarget %h Busy %b required 0/1/%h/1",
               bus.IRValid, bus.PCLoad, bus.PCTarget, bus.Busy, tgt);
    end
    repeat (2) step();
    tests_run++;
    if (bus.MemAddr !== tgt || load_cnt != ld0 + 1) begin
      tests_failed++;
      $display("FAIL bh_target: addr %h loads %0d required %h/1", bus.MemAddr, load_cnt - ld0, tgt);
    end
    wait_valid(n);
    tests_run++;
    if (bus.IR !== mem[tgt[7:0]]) begin
      tests_failed++;
      $display("FAIL bh_fetch: IR %h required %h", bus.IR, mem[tgt[7:0]]);
    end
  endtask

  task automatic test_reset_mid_wait();
    int inc0;
    int ld0;
    do_reset();
    repeat (2) step();
    inc0 = incr_cnt;
    ld0  = load_cnt;
    #2 Resetn = 1'b0;
    #1;
    tests_run++;
    if ({bus.MemAddr, bus.IR, bus.PCTarget, bus.IRValid, bus.PCIncr, bus.PCLoad, bus.Busy} !== '0) begin
      tests_failed++;
      $display("FAIL midwait_reset: got %h required 0",
               {bus.MemAddr, bus.IR, bus.PCTarget, bus.IRValid, bus.PCIncr, bus.PCLoad, bus.Busy});
    end
    bus.Run = 1'b0;
    repeat (2) step();
    Resetn = 1'b1;
    repeat (3) step();
    tests_run++;
    if (bus.Busy !== 1'b0 || incr_cnt != inc0 || load_cnt != ld0) begin
      tests_failed++;
      $display("FAIL midwait_after: Busy %b incr %0d load %0d required 0/0/0",
               bus.Busy, incr_cnt - inc0, load_cnt - ld0);
    end
  endtask

  // Continues from test_reset_mid_wait: block idle with Run=0, PC=0.
  task automatic test_run_stop();
    int n;
    bus.Run = 1'b1;
    wait_valid(n);
    bus.Run = 1'b0;
    bus.IRReady = 1'b1;
    step();
    bus.IRReady = 1'b0;
    tests_run++;
    if (bus.IRValid !== 1'b0 || bus.Busy !== 1'b0 || bus.IR !== mem[0]) begin
      tests_failed++;
      $display("FAIL runstop_idle: IRValid %b Busy %b IR %h required 0/0/%h",
               bus.IRValid, bus.Busy, bus.IR, mem[0]);
    end
    bus.BranchReq = 1'b1; bus.BranchAddr = 16'h0077;
    step();
    bus.BranchReq = 1'b0;
    repeat (3) step();
    tests_run++;
    if (bus.Busy !== 1'b0 || bus.PCLoad !== 1'b0 || bus.MemAddr !== 16'h0000) begin
      tests_failed++;
      $display("FAIL idle_branch: Busy %b PCLoad %b addr %h required 0/0/0000",
               bus.Busy, bus.PCLoad, bus.MemAddr);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    incr_cnt     = 0;
    load_cnt     = 0;
    overlap_cnt  = 0;
    Resetn       = 1'b0;
    bus.Run = 1'b0; bus.IRReady = 1'b0; bus.BranchReq = 1'b0; bus.BranchAddr = '0;
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    mem[0] = 16'h1234;

    test_reset();
    test_backpressure();
    test_stream();
    test_random_stream();
    test_branch_wait();
    test_branch_handshake();
    test_reset_mid_wait();
    test_run_stop();

    tests_run++;
    if (overlap_cnt != 0) begin
      tests_failed++;
      $display("FAIL incr_load_overlap: got %0d cycles required 0", overlap_cnt);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
